soc_system_pio_capture: RTL and testbench

//  Parametrised Avalon-MM input PIO with synchroniser, per-bit debounce, per-bit

---
 rtl/soc_system_pio_capture_if.sv | 25 ++
 rtl/soc_system_pio_capture.sv | 125 ++++++++++++
 tb/tb_soc_system_pio_capture.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/soc_system_pio_capture_if.sv
// Avalon-MM slave bus bundle for the soc_system input PIO.
// Master side is the HPS lightweight bridge; slave side is the PIO register block.
interface soc_system_pio_capture_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/soc_system_pio_capture.sv
// Avalon-MM input PIO: synchroniser, per-bit debounce, selectable edge capture
// with write-1-to-clear, and masked level interrupt.
module soc_system_pio_capture #(
   parameter int unsigned      WIDTH           = 12,
   parameter int unsigned      SYNC_STAGES     = 2,
   parameter int unsigned      DEBOUNCE_CYCLES = 0,
   parameter logic [WIDTH-1:0] RISE_DEFAULT    = '1,
   parameter logic [WIDTH-1:0] FALL_DEFAULT    = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   soc_system_pio_capture_if.slave  avs,
   input  logic [WIDTH-1:0]         in_port,
   output logic                     irq
);

   localparam int unsigned CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam int unsigned CNT_LAST = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0;
   localparam logic [CW-1:0] CNT_LAST_V = CW'(CNT_LAST);

   typedef enum logic [2:0] {
      A_DATA = 3'd0,
      A_RAW  = 3'd1,
      A_MASK = 3'd2,
      A_CAP  = 3'd3,
      A_RISE = 3'd4,
      A_FALL = 3'd5
   } reg_addr_e;

   logic [WIDTH-1:0] r_sync [SYNC_STAGES];
   logic [CW-1:0]    r_cnt  [WIDTH];
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_cap;
   logic [WIDTH-1:0] r_rise;
   logic [WIDTH-1:0] r_fall;
   logic [31:0]      r_rdata;

   logic             w_wr;
   logic [WIDTH-1:0] w_raw;
   logic [WIDTH-1:0] w_wdata;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_clr;
   logic [31:0]      w_rmux;

   assign w_wr    = avs.chipselect & ~avs.write_n;
   assign w_raw   = r_sync[SYNC_STAGES-1];
   assign w_wdata = avs.writedata[WIDTH-1:0];
   assign w_edge  = (r_data & ~r_prev & r_rise) | (~r_data & r_prev & r_fall);
   assign w_clr   = (w_wr && (avs.address == A_CAP)) ? w_wdata : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      end else begin
         r_sync[0] <= in_port;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   // A bit only follows RAW after it has differed from DATA for the full count;
   // any return to DATA zeroes the count so glitches restart it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data <= '0;
         for (int unsigned i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (w_raw[i] == r_data[i]) begin
               r_cnt[i] <= '0;
            end else if ((DEBOUNCE_CYCLES <= 1) || (r_cnt[i] == CNT_LAST_V)) begin
               r_data[i] <= w_raw[i];
               r_cnt[i]  <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev <= '0;
         r_mask <= '0;
         r_cap  <= '0;
         r_rise <= RISE_DEFAULT;
         r_fall <= FALL_DEFAULT;
      end else begin
         r_prev <= r_data;
         // New edges are OR-ed in after the clear so a coincident edge survives.
         r_cap  <= (r_cap & ~w_clr) | w_edge;
         if (w_wr) begin
            case (avs.address)
               A_MASK:  r_mask <= w_wdata;
               A_RISE:  r_rise <= w_wdata;
               A_FALL:  r_fall <= w_wdata;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      w_rmux = '0;
      case (avs.address)
         A_DATA:  w_rmux[WIDTH-1:0] = r_data;
         A_RAW:   w_rmux[WIDTH-1:0] = w_raw;
         A_MASK:  w_rmux[WIDTH-1:0] = r_mask;
         A_CAP:   w_rmux[WIDTH-1:0] = r_cap;
         A_RISE:  w_rmux[WIDTH-1:0] = r_rise;
         A_FALL:  w_rmux[WIDTH-1:0] = r_fall;
         default: w_rmux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_rdata <= '0;
      else       r_rdata <= w_rmux;
   end

   assign avs.readdata = r_rdata;
   assign irq          = |(r_cap & r_mask);

endmodule

// File: tb/tb_soc_system_pio_capture.sv
// Directed bench for the input PIO: one instance without debounce, one with an
// 8-cycle debounce; expectations queue in a scoreboard and are checked on output.
module tb_soc_system_pio_capture;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] in0;
   logic [11:0] in8;
   logic        irq0;
   logic        irq8;

   always #5 clk = ~clk;

   soc_system_pio_capture_if bus0 ();
   soc_system_pio_capture_if bus8 ();

   soc_system_pio_capture #(
      .WIDTH           (12),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (0)
   ) u_dut0 (
      .clk     (clk),
      .reset   (reset),
      .avs     (bus0),
      .in_port (in0),
      .irq     (irq0)
   );

   soc_system_pio_capture #(
      .WIDTH           (12),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (8)
   ) u_dut8 (
      .clk     (clk),
      .reset   (reset),
      .avs     (bus8),
      .in_port (in8),
      .irq     (irq8)
   );

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic push(input string tag, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed 0x%08h, required a queued expectation", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_addr(input int sel, input logic [2:0] a);
      if (sel == 0) bus0.address = a;
      else          bus8.address = a;
   endtask

   task automatic rd(input int sel, input logic [2:0] a, input logic [31:0] exp, input string tag);
      push(tag, exp);
      set_addr(sel, a);
      tick(1);
      check((sel == 0) ? bus0.readdata : bus8.readdata);
   endtask

   task automatic wr(input int sel, input logic [2:0] a, input logic [31:0] d);
      if (sel == 0) begin
         bus0.address = a; bus0.writedata = d; bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
      end else begin
         bus8.address = a; bus8.writedata = d; bus8.chipselect = 1'b1; bus8.write_n = 1'b0;
      end
      tick(1);
      bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
      bus8.chipselect = 1'b0; bus8.write_n = 1'b1;
   endtask

   task automatic chk_irq(input logic obs, input logic exp, input string tag);
      push(tag, {31'b0, exp});
      check({31'b0, obs});
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      in0 = '0;
      in8 = '0;
      bus0.address = '0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = '0;
      bus8.address = '0; bus8.chipselect = 1'b0; bus8.write_n = 1'b1; bus8.writedata = '0;
      tick(3);
      reset = 1'b0;
      tick(1);

      // Reset values
      rd(0, 3'd4, 32'h0000_0FFF, "rst_rise");
      for (int a = 0; a < 8; a++) begin
         logic [2:0] aa;
         aa = a[2:0];
         if (a != 4) rd(0, aa, 32'h0, $sformatf("rst_addr%0d", a));
      end
      rd(1, 3'd4, 32'h0000_0FFF, "rst_rise_db8");
      chk_irq(irq0, 1'b0, "rst_irq0");
      chk_irq(irq8, 1'b0, "rst_irq8");

      // No debounce: DATA at edge 3, capture/irq at edge 4
      wr(0, 3'd2, 32'h1);
      set_addr(0, 3'd0);
      in0 = 12'h001;
      tick(3);
      push("data_edge3_old", 32'h0); check(bus0.readdata);
      chk_irq(irq0, 1'b0, "irq_edge3");
      tick(1);
      push("data_edge4", 32'h1); check(bus0.readdata);
      chk_irq(irq0, 1'b1, "irq_edge4");
      rd(0, 3'd3, 32'h1, "cap_bit0");
      rd(0, 3'd1, 32'h1, "raw_bit0");
      wr(0, 3'd3, 32'h1);
      chk_irq(irq0, 1'b0, "irq_after_w1c");
      rd(0, 3'd3, 32'h0, "cap_cleared");

      // Falling-only capture on bit1, masked then unmasked
      wr(0, 3'd4, 32'h0);
      wr(0, 3'd5, 32'h2);
      wr(0, 3'd2, 32'h0);
      in0 = 12'h003;
      tick(6);
      rd(0, 3'd3, 32'h0, "rise_disabled");
      rd(0, 3'd0, 32'h3, "data_bit1");
      in0 = 12'h001;
      tick(6);
      rd(0, 3'd3, 32'h2, "fall_cap");
      chk_irq(irq0, 1'b0, "irq_masked");
      wr(0, 3'd2, 32'h2);
      chk_irq(irq0, 1'b1, "irq_unmask");
      rd(0, 3'd3, 32'h2, "cap_after_unmask");

      // Edge on bit5 coincident with its W1C write: set wins
      wr(0, 3'd4, 32'h20);
      wr(0, 3'd5, 32'h0);
      wr(0, 3'd3, 32'hFFF);
      chk_irq(irq0, 1'b0, "irq_cleared_all");
      in0 = 12'h021;
      tick(3);
      wr(0, 3'd3, 32'h20);
      rd(0, 3'd3, 32'h20, "set_wins");
      wr(0, 3'd3, 32'h20);
      rd(0, 3'd3, 32'h0, "w1c_bit5");

      // Debounce 8: short pulse rejected
      in8 = 12'h008;
      tick(5);
      in8 = 12'h000;
      tick(15);
      rd(1, 3'd0, 32'h0, "pulse_data");
      rd(1, 3'd3, 32'h0, "pulse_cap");

      // Debounce 8: stable level accepted at edge 10
      set_addr(1, 3'd0);
      in8 = 12'h008;
      tick(10);
      push("db_not_early", 32'h0); check(bus8.readdata);
      tick(1);
      push("db_latency", 32'h8); check(bus8.readdata);
      rd(1, 3'd3, 32'h8, "db_cap");
      in8 = 12'h000;
      tick(20);

      // Reset while bit2 count is at 5
      wr(1, 3'd3, 32'hFFF);
      rd(1, 3'd0, 32'h0, "data_back_low");
      in8 = 12'h004;
      tick(7);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      in8 = 12'h000;
      tick(15);
      rd(1, 3'd0, 32'h0, "rst_db_data");
      rd(1, 3'd3, 32'h0, "rst_db_cap");
      chk_irq(irq8, 1'b0, "rst_db_irq");
      rd(1, 3'd4, 32'h0000_0FFF, "rst_db_rise");
      rd(0, 3'd4, 32'h0000_0FFF, "rst_mid_rise0");
      rd(0, 3'd2, 32'h0, "rst_mid_mask0");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
